// File: rtl/lsu_if.sv
// ============================================================================
// Module      : lsu_if
// Description : Request, data-memory and writeback signal bundle for the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        rsp_err;

    // LSU side
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        input  mem_ack, mem_rdata,
        output req_ready,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output rsp_valid, rsp_rdata, rsp_rd, rsp_err
    );

    // Pipeline / memory side
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        output mem_ack, mem_rdata,
        input  req_ready,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  rsp_valid, rsp_rdata, rsp_rd, rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
// Module      : lsu
// Description : Single-outstanding load/store unit with lane steering and
//               sign/zero extension. Misaligned accesses error without bus use.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic rst_n,
    lsu_if.slave      bus,
    output logic      busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [1:0]              off;
    logic [1:0]              size;
    logic                    is_unsigned;
    logic                    is_store;
    logic [4:0]              rd;

    logic                    misaligned;
    logic [3:0]              be_next;
    logic [DATA_WIDTH-1:0]   wdata_next;
    logic [DATA_WIDTH-1:0]   load_shift;
    logic [DATA_WIDTH-1:0]   load_ext;

    assign bus.req_ready = (state == IDLE);
    assign busy          = (state != IDLE);

    always_comb begin
        misaligned = 1'b0;
        be_next    = 4'b1111;
        wdata_next = bus.req_wdata;
        unique case (bus.req_size)
            2'b00: begin
                be_next    = 4'b0001 << bus.req_addr[1:0];
                wdata_next = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = bus.req_addr[0];
                be_next    = 4'b0011 << bus.req_addr[1:0];
                wdata_next = {2{bus.req_wdata[15:0]}};
            end
            2'b10: begin
                misaligned = |bus.req_addr[1:0];
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0 before extending.
    always_comb begin
        load_shift = bus.mem_rdata >> {off, 3'b000};
        load_ext   = load_shift;
        unique case (size)
            2'b00:   load_ext = is_unsigned ? {24'd0, load_shift[7:0]}
                                            : {{24{load_shift[7]}}, load_shift[7:0]};
            2'b01:   load_ext = is_unsigned ? {16'd0, load_shift[15:0]}
                                            : {{16{load_shift[15]}}, load_shift[15:0]};
            default: load_ext = load_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            off           <= 2'b00;
            size          <= 2'b00;
            is_unsigned   <= 1'b0;
            is_store      <= 1'b0;
            rd            <= 5'd0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= 4'b0000;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_rd    <= 5'd0;
            bus.rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        off         <= bus.req_addr[1:0];
                        size        <= bus.req_size;
                        is_unsigned <= bus.req_unsigned;
                        is_store    <= bus.req_we;
                        rd          <= bus.req_rd;
                        if (misaligned) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                            bus.rsp_rd    <= bus.req_rd;
                        end else begin
                            state         <= BUS;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.req_we;
                            bus.mem_be    <= be_next;
                            bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            bus.mem_wdata <= wdata_next;
                        end
                    end
                end
                BUS: begin
                    if (bus.mem_ack) begin
                        state         <= RESP;
                        bus.mem_req   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rd    <= rd;
                        bus.rsp_rdata <= is_store ? '0 : load_ext;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
// Module      : tb_lsu
// Description : Directed vector bench for the LSU with multi-cycle corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu;

    logic clk;
    logic rst_n;
    logic busy;

    lsu_if bus ();

    lsu #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] rsp;
    } vec_t;

    vec_t vecs[11];

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        @(negedge clk);
        chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_rd       = rd;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid    = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input logic [4:0] rd);
        issue(v.we, v.size, v.uns, v.addr, v.wdata, rd);
        if (v.err) begin
            chk("mis_mem_req", {31'd0, bus.mem_req}, 32'd0);
            chk("mis_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("mis_rsp_err", {31'd0, bus.rsp_err}, 32'd1);
            chk("mis_rsp_rd", {27'd0, bus.rsp_rd}, {27'd0, rd});
        end else begin
            chk("mem_req", {31'd0, bus.mem_req}, 32'd1);
            chk("mem_we", {31'd0, bus.mem_we}, {31'd0, v.we});
            chk("mem_be", {28'd0, bus.mem_be}, {28'd0, v.be});
            chk("mem_addr", bus.mem_addr, v.maddr);
            if (v.we) chk("mem_wdata", bus.mem_wdata, v.mwdata);
            chk("rsp_valid_early", {31'd0, bus.rsp_valid}, 32'd0);
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = v.rdata;
            @(posedge clk);
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("rsp_rdata", bus.rsp_rdata, v.rsp);
            chk("rsp_err", {31'd0, bus.rsp_err}, 32'd0);
            chk("rsp_rd", {27'd0, bus.rsp_rd}, {27'd0, rd});
            chk("mem_req_resp", {31'd0, bus.mem_req}, 32'd0);
        end
        @(negedge clk);
        chk("rsp_valid_drop", {31'd0, bus.rsp_valid}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        //         we    size   uns   addr          wdata         rdata         err   be       maddr         mwdata        rsp
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        32'h80AA_BBCC, 1'b0, 4'b1000, 32'h0000_1000, 32'h0,        32'hFFFF_FF80};
        vecs[1]  = '{1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,        32'hF00D_1234, 1'b0, 4'b1100, 32'h0000_2000, 32'h0,        32'h0000_F00D};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h1234_56AB, 32'hDEAD_BEEF, 1'b0, 4'b0010, 32'h0000_3000, 32'hABAB_ABAB, 32'h0};
        vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0,        32'h0};
        vecs[4]  = '{1'b0, 2'b11, 1'b0, 32'h0000_4000, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0,        32'h0};
        vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0000_5000, 32'h0,        32'h1234_8001, 1'b0, 4'b0011, 32'h0000_5000, 32'h0,        32'hFFFF_8001};
        vecs[6]  = '{1'b0, 2'b00, 1'b1, 32'h0000_6002, 32'h0,        32'h119A_2233, 1'b0, 4'b0100, 32'h0000_6000, 32'h0,        32'h0000_009A};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'h0,        32'hCAFE_BABE, 1'b0, 4'b1111, 32'h0000_7000, 32'h0,        32'hCAFE_BABE};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h0000_8002, 32'hAAAA_5678, 32'h5555_5555, 1'b0, 4'b1100, 32'h0000_8000, 32'h5678_5678, 32'h0};
        vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h0000_9001, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0,        32'h0};
        vecs[10] = '{1'b0, 2'b00, 1'b0, 32'h0000_A001, 32'h0,        32'h0000_7F00, 1'b0, 4'b0010, 32'h0000_A000, 32'h0,        32'h0000_007F};

        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.req_rd       = 5'd0;
        bus.mem_ack      = 1'b0;
        bus.mem_rdata    = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], 5'(i + 1));

        // mem_ack while idle must not produce a response
        @(negedge clk);
        bus.mem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("idle_ack_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        chk("idle_ack_busy", {31'd0, busy}, 32'd0);

        // sw with a 5-cycle delayed ack
        issue(1'b1, 2'b10, 1'b0, 32'h0000_B000, 32'h0102_0304, 5'd20);
        for (int c = 0; c < 5; c++) begin
            chk("dly_mem_req", {31'd0, bus.mem_req}, 32'd1);
            chk("dly_mem_addr", bus.mem_addr, 32'h0000_B000);
            chk("dly_mem_be", {28'd0, bus.mem_be}, 32'hF);
            chk("dly_mem_wdata", bus.mem_wdata, 32'h0102_0304);
            chk("dly_busy", {31'd0, busy}, 32'd1);
            chk("dly_req_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("dly_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        chk("dly_rsp_valid_hi", {31'd0, bus.rsp_valid}, 32'd1);
        chk("dly_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("dly_rsp_rd", {27'd0, bus.rsp_rd}, 32'd20);
        @(negedge clk);
        chk("dly_rsp_drop", {31'd0, bus.rsp_valid}, 32'd0);

        // reset during BUS, then a late ack
        issue(1'b0, 2'b10, 1'b0, 32'h0000_C000, 32'h0, 5'd7);
        chk("rb_mem_req_before", {31'd0, bus.mem_req}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rb_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rb_busy", {31'd0, busy}, 32'd0);
        chk("rb_mem_be", {28'd0, bus.mem_be}, 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        chk("rb_late_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rb_late_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("rb_late_rsp2", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rb_ready", {31'd0, bus.req_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 32 (from my_pkg), data and address width; only 32 is supported.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  synchronous reset, active-low.
REQ-004 SHALL have ports: req_valid in 1, req_ready out 1  request handshake from EX stage.
REQ-005 SHALL have ports: req_we in 1 (1=store), req_size in 2 (00 byte, 01 half, 10 word, 11 illegal), req_unsigned in 1 (zero-extend load).
REQ-006 SHALL have ports: req_addr in 32 (ALU result), req_wdata in 32 (rs2 value), req_rd in 5 (destination register tag).
REQ-007 SHALL have ports: mem_req out 1, mem_we out 1, mem_be out 4, mem_addr out 32, mem_wdata out 32  data-memory request.
REQ-008 SHALL have ports: mem_ack in 1, mem_rdata in 32  memory completion; rdata valid when mem_ack=1.
REQ-009 SHALL have ports: rsp_valid out 1, rsp_rdata out 32, rsp_rd out 5, rsp_err out 1  response to writeback.
REQ-010 SHALL have port: busy out 1  high whenever state is not IDLE (pipeline stall).

Function
REQ-011 SHALL implement FSM states IDLE, BUS, RESP.
REQ-012 SHALL drive req_ready=1 only in IDLE; accept when req_valid and req_ready are both 1; latch all req_* fields on accept.
REQ-013 SHALL flag misalignment: half with addr[0]=1, word with addr[1:0]!=00, or size=11; misaligned accept -> RESP directly, rsp_err=1, no mem_req issued.
REQ-014 SHALL, on an aligned accept, go IDLE->BUS; in BUS hold mem_req=1 and all mem_* outputs stable until the cycle mem_ack=1.
REQ-015 SHALL drive mem_addr = latched addr with bits [1:0] forced to 00.
REQ-016 SHALL generate mem_be: byte -> 0001<<addr[1:0]; half -> 0011<<addr[1:0]; word -> 1111; loads use the same mask.
REQ-017 SHALL replicate store data across lanes: byte -> {4{wdata[7:0]}}, half -> {2{wdata[15:0]}}, word -> wdata.
REQ-018 SHALL, on mem_ack in BUS, shift mem_rdata right by 8*addr[1:0], sign- or zero-extend per size and req_unsigned, register into rsp_rdata, go to RESP.
REQ-019 SHALL, for stores, return rsp_rdata=0.
REQ-020 SHALL assert rsp_valid for exactly one cycle in RESP with rsp_rd = latched rd, then return to IDLE; there is no response backpressure.
REQ-021 SHALL hold rsp_rdata, rsp_rd, rsp_err stable outside RESP; they are only meaningful when rsp_valid=1.
REQ-022 SHALL ignore mem_ack outside BUS.
REQ-023 SHALL have minimum latency: accept in cycle N, mem_req in N+1, mem_ack in N+1, rsp_valid in N+2; misaligned: rsp_valid in N+1.
REQ-024 SHALL keep mem_req=0 in IDLE and RESP; back-to-back requests are therefore spaced by at least one idle cycle.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, force state IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_rd=0, rsp_err=0.
REQ-026 SHALL abandon an outstanding BUS transaction on reset (mem_req drops the next edge); a late mem_ack after reset is ignored.

Verification
REQ-027 SHALL cover: lb addr=0x1003, mem_rdata=0x80AABBCC, ack immediate -> mem_addr=0x1000, mem_be=1000, rsp_rdata=0xFFFFFF80 two cycles after accept.
REQ-028 SHALL cover: lhu addr=0x2002, mem_rdata=0xF00D1234 -> mem_be=1100, rsp_rdata=0x0000F00D.
REQ-029 SHALL cover: sb addr=0x3001, wdata=0x123456AB -> mem_we=1, mem_be=0010, mem_wdata=0xABABABAB, rsp_valid with rsp_rdata=0, rsp_err=0.
REQ-030 SHALL cover: lw addr=0x4002 -> no mem_req, rsp_valid one cycle after accept with rsp_err=1; size=11 gives the same result.
REQ-031 SHALL cover: sw with mem_ack delayed 5 cycles -> mem_req and mem_* stable for 5 cycles, busy=1, req_ready=0 throughout.
REQ-032 SHALL cover: rst_n=0 during BUS, then mem_ack pulses after release -> mem_req=0, state IDLE, no rsp_valid.
